// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM ring stream reader.
//   PACKET_WORDS   : words per packet emitted on the stream
//   OUT_FIFO_DEPTH : entries in the output skid FIFO
//   reader_state_e : reader FSM encoding (also exported on the state port)
package bram_stream_reader_pkg;

  localparam int unsigned PACKET_WORDS   = 144;
  localparam int unsigned OUT_FIFO_DEPTH = 4;
  localparam int unsigned OUT_FIFO_CNT_W = $clog2(OUT_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } reader_state_e;

endpackage

// File: rtl/stream_out_fifo.sv
// Small synchronous FIFO that buffers BRAM read data (plus tlast tag) in
// front of the AXI-Stream master.
//   clk, rstn : clock, asynchronous active-low reset
//   wr_en     : push wr_data (ignored when full)
//   wr_data   : {last, data}
//   rd_en     : pop head entry (ignored when empty)
//   rd_data   : head entry, stable until popped
//   empty     : no entries held
//   count     : number of entries held
module stream_out_fifo
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 33
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      empty,
  output logic [OUT_FIFO_CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(OUT_FIFO_DEPTH);
  localparam logic [OUT_FIFO_CNT_W-1:0] FULL_CNT = OUT_FIFO_CNT_W'(OUT_FIFO_DEPTH);

  logic [WIDTH-1:0]          mem [OUT_FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [OUT_FIFO_CNT_W-1:0] cnt;
  logic                      full;
  logic                      do_wr;
  logic                      do_rd;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign count   = cnt;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is reset so the stream data output reads zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < OUT_FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Reads fixed-size packets out of a BRAM ring (port B) that another agent
// fills through port A, and emits them on an AXI-Stream master.
//   clk, rstn        : clock, asynchronous active-low reset
//   enable           : stream enable; a started packet always completes
//   clear            : clears overflow / overflow_count
//   wr_strobe        : one pulse per word committed by the writer
//   write_ptr        : writer's next word address
//   bram_*           : BRAM port B (read-only use)
//   m_axis_*         : AXI-Stream master
//   read_ptr         : next word address to read
//   occupancy        : words written but not yet read
//   overflow(_count) : sticky writer-overrun flag and saturating count
//   state            : reader FSM state
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned BRAM_ADDR_WIDTH   = 16,
  parameter int unsigned BRAM_DATA_WIDTH   = 32,
  parameter int unsigned BRAM_DEPTH_WORDS  = 16384,
  parameter int unsigned PACKET_WORDS      = bram_stream_reader_pkg::PACKET_WORDS,
  parameter int unsigned BRAM_READ_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       wr_strobe,
  input  logic [13:0]                write_ptr,
  output logic                       bram_clk,
  output logic                       bram_rst,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0] bram_din,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_dout,
  output logic                       bram_en,
  output logic [3:0]                 bram_we,
  output logic [31:0]                m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [13:0]                read_ptr,
  output logic [14:0]                occupancy,
  output logic                       overflow,
  output logic [15:0]                overflow_count,
  output logic [1:0]                 state
);

  localparam int unsigned PTR_W = 14;
  localparam int unsigned OCC_W = 15;
  localparam int unsigned IDX_W = $clog2(PACKET_WORDS);
  localparam int unsigned LAT   = BRAM_READ_LATENCY;

  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(BRAM_DEPTH_WORDS - 1);
  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(BRAM_DEPTH_WORDS);
  localparam logic [OCC_W-1:0] OCC_PACKET = OCC_W'(PACKET_WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(PACKET_WORDS - 1);
  localparam logic [OUT_FIFO_CNT_W:0] OUTSTANDING_MAX = (OUT_FIFO_CNT_W + 1)'(OUT_FIFO_DEPTH);

  reader_state_e st, st_nxt;

  logic [IDX_W-1:0]          word_idx;
  logic [OUT_FIFO_CNT_W-1:0] inflight;
  logic [OUT_FIFO_CNT_W-1:0] fifo_count;
  logic [OUT_FIFO_CNT_W:0]   outstanding;
  logic [LAT-1:0]            rd_vld_pipe;
  logic [LAT-1:0]            rd_last_pipe;
  logic                      issue;
  logic                      last_issue;
  logic                      land;
  logic                      load;
  logic                      ovf_evt;
  logic                      fifo_empty;
  logic [32:0]               fifo_rd_data;

  // ---------------------------------------------------------------------
  // BRAM port B: read-only, word address on a byte-addressed bus
  // ---------------------------------------------------------------------
  assign bram_clk  = clk;
  assign bram_rst  = ~rstn;
  assign bram_we   = '0;
  assign bram_din  = '0;
  assign bram_addr = BRAM_ADDR_WIDTH'({read_ptr, 2'b00});
  assign bram_en   = issue;

  // Reads are only issued while every outstanding word (in the BRAM
  // pipeline or already buffered) is guaranteed a FIFO slot, so the FIFO
  // can never overflow regardless of tready.
  assign outstanding = {1'b0, inflight} + {1'b0, fifo_count};
  assign issue       = (st == ST_STREAM) && (outstanding < OUTSTANDING_MAX);
  assign last_issue  = issue && (word_idx == IDX_LAST);
  assign land        = rd_vld_pipe[LAT-1];
  assign load        = (st == ST_IDLE) && enable;
  assign ovf_evt     = wr_strobe && !issue && !load && (occupancy == OCC_FULL);

  assign state = st;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st <= ST_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: begin
        if (enable) st_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!enable)                      st_nxt = ST_IDLE;
        else if (occupancy >= OCC_PACKET) st_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        // enable is only consulted at the packet boundary
        if (last_issue) st_nxt = enable ? ST_WAIT : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty && (inflight == '0)) st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Pointers, occupancy and overflow status
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      read_ptr       <= '0;
      word_idx       <= '0;
      occupancy      <= '0;
      overflow       <= 1'b0;
      overflow_count <= '0;
    end else begin
      if (load) begin
        read_ptr <= write_ptr;
      end else if (issue) begin
        read_ptr <= (read_ptr == PTR_LAST) ? '0 : read_ptr + 1'b1;
      end

      if (issue) begin
        word_idx <= (word_idx == IDX_LAST) ? '0 : word_idx + 1'b1;
      end

      if (load) begin
        occupancy <= '0;
      end else begin
        case ({wr_strobe, issue})
          2'b10:   if (occupancy != OCC_FULL) occupancy <= occupancy + 1'b1;
          2'b01:   occupancy <= occupancy - 1'b1;
          default: occupancy <= occupancy;
        endcase
      end

      if (clear) begin
        overflow       <= 1'b0;
        overflow_count <= '0;
      end else if (ovf_evt) begin
        overflow <= 1'b1;
        if (overflow_count != '1) overflow_count <= overflow_count + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read-latency tracking: a valid/last pair shifts alongside each read so
  // that bram_dout is captured exactly LAT cycles after its bram_en.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld_pipe  <= '0;
      rd_last_pipe <= '0;
      inflight     <= '0;
    end else begin
      rd_vld_pipe[0]  <= issue;
      rd_last_pipe[0] <= last_issue;
      for (int unsigned i = 1; i < LAT; i++) begin
        rd_vld_pipe[i]  <= rd_vld_pipe[i-1];
        rd_last_pipe[i] <= rd_last_pipe[i-1];
      end
      case ({issue, land})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output FIFO and AXI-Stream master
  // ---------------------------------------------------------------------
  stream_out_fifo #(
    .WIDTH (33)
  ) u_out_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (land),
    .wr_data ({rd_last_pipe[LAT-1], bram_dout[31:0]}),
    .rd_en   (m_axis_tready),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_rd_data[31:0];
  assign m_axis_tlast  = fifo_rd_data[32];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader. Two instances run from the same
// stimulus: one with a 1-cycle BRAM read latency, one with 2 cycles. Each
// has its own BRAM model whose word at address w is {18'h2C0DE, w}.
module tb_bram_stream_reader;

  localparam int PW    = 144;
  localparam int DEPTH = 16384;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        clear;
  logic        wr_strobe;
  logic [13:0] write_ptr;
  logic        tready;

  logic        bram_clk_1, bram_rst_1, bram_en_1, tvalid_1, tlast_1, ovf_1;
  logic [15:0] bram_addr_1, ovf_cnt_1;
  logic [31:0] bram_din_1, bram_dout_1, tdata_1;
  logic [3:0]  bram_we_1;
  logic [13:0] read_ptr_1;
  logic [14:0] occ_1;
  logic [1:0]  state_1;

  logic        bram_clk_2, bram_rst_2, bram_en_2, tvalid_2, tlast_2, ovf_2;
  logic [15:0] bram_addr_2, ovf_cnt_2;
  logic [31:0] bram_din_2, bram_dout_2, tdata_2;
  logic [3:0]  bram_we_2;
  logic [13:0] read_ptr_2;
  logic [14:0] occ_2;
  logic [1:0]  state_2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [13:0] w);
    return {18'h2C0DE, w};
  endfunction

  bram_stream_reader #(.BRAM_READ_LATENCY(1)) dut_l1 (
    .clk(clk), .rstn(rstn), .enable(enable), .clear(clear), .wr_strobe(wr_strobe),
    .write_ptr(write_ptr), .bram_clk(bram_clk_1), .bram_rst(bram_rst_1),
    .bram_addr(bram_addr_1), .bram_din(bram_din_1), .bram_dout(bram_dout_1),
    .bram_en(bram_en_1), .bram_we(bram_we_1), .m_axis_tdata(tdata_1),
    .m_axis_tvalid(tvalid_1), .m_axis_tready(tready), .m_axis_tlast(tlast_1),
    .read_ptr(read_ptr_1), .occupancy(occ_1), .overflow(ovf_1),
    .overflow_count(ovf_cnt_1), .state(state_1));

  bram_stream_reader #(.BRAM_READ_LATENCY(2)) dut_l2 (
    .clk(clk), .rstn(rstn), .enable(enable), .clear(clear), .wr_strobe(wr_strobe),
    .write_ptr(write_ptr), .bram_clk(bram_clk_2), .bram_rst(bram_rst_2),
    .bram_addr(bram_addr_2), .bram_din(bram_din_2), .bram_dout(bram_dout_2),
    .bram_en(bram_en_2), .bram_we(bram_we_2), .m_axis_tdata(tdata_2),
    .m_axis_tvalid(tvalid_2), .m_axis_tready(tready), .m_axis_tlast(tlast_2),
    .read_ptr(read_ptr_2), .occupancy(occ_2), .overflow(ovf_2),
    .overflow_count(ovf_cnt_2), .state(state_2));

  // BRAM models
  logic [31:0] b1_q, b2_q1, b2_q2;
  always @(posedge clk) begin
    if (bram_en_1) b1_q <= word_of(bram_addr_1[15:2]);
    if (bram_en_2) b2_q1 <= word_of(bram_addr_2[15:2]);
    b2_q2 <= b2_q1;
  end
  assign bram_dout_1 = b1_q;
  assign bram_dout_2 = b2_q2;

  // Stream monitor: records transfers and counts tdata/tlast changes while stalled
  logic [32:0] q1[$], q2[$];
  int          stamp1[$];
  int          cyc = 0;
  int          stall_err1 = 0, stall_err2 = 0;
  logic        hold1 = 1'b0, hold2 = 1'b0;
  logic [32:0] held1, held2;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rstn) begin
      hold1 = 1'b0;
      hold2 = 1'b0;
    end else begin
      if (hold1 && tvalid_1 && ({tlast_1, tdata_1} !== held1)) stall_err1++;
      if (hold2 && tvalid_2 && ({tlast_2, tdata_2} !== held2)) stall_err2++;
      if (tvalid_1 && tready) begin
        q1.push_back({tlast_1, tdata_1});
        stamp1.push_back(cyc);
      end
      if (tvalid_2 && tready) q2.push_back({tlast_2, tdata_2});
      hold1 = tvalid_1 && !tready;
      held1 = {tlast_1, tdata_1};
      hold2 = tvalid_2 && !tready;
      held2 = {tlast_2, tdata_2};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      wr_strobe = 1'b1;
      tick();
    end
    wr_strobe = 1'b0;
  endtask

  // Waits (bounded) until both monitors hold n words; rnd selects 30% tready
  task automatic wait_words(input int n, input int max_cycles, input bit rnd);
    int k;
    k = 0;
    while ((q1.size() < n || q2.size() < n) && k < max_cycles) begin
      if (rnd) tready = ($urandom_range(0, 99) < 30);
      tick();
      k++;
    end
    tready = 1'b1;
    repeat (6) tick();
  endtask

  task automatic clear_queues();
    q1.delete();
    q2.delete();
    stamp1.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b0; clear = 1'b0; wr_strobe = 1'b0;
    write_ptr = '0; tready = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({state_1, read_ptr_1, occ_1, ovf_1, ovf_cnt_1} !== '0) begin
      n_bad++;
      $display("FAIL reset_status_l1: got %h expected 0", {state_1, read_ptr_1, occ_1, ovf_1, ovf_cnt_1});
    end
    n_cmp++;
    if ({state_2, read_ptr_2, occ_2, ovf_2, ovf_cnt_2} !== '0) begin
      n_bad++;
      $display("FAIL reset_status_l2: got %h expected 0", {state_2, read_ptr_2, occ_2, ovf_2, ovf_cnt_2});
    end
    n_cmp++;
    if ({tvalid_1, tlast_1, tdata_1, tvalid_2, tlast_2, tdata_2} !== '0) begin
      n_bad++;
      $display("FAIL reset_axis: got %h expected 0", {tvalid_1, tlast_1, tdata_1, tvalid_2, tlast_2, tdata_2});
    end
    n_cmp++;
    if ({bram_en_1, bram_rst_1, bram_we_1, bram_din_1, bram_addr_1} !== {1'b0, 1'b1, 4'h0, 32'h0, 16'h0}) begin
      n_bad++;
      $display("FAIL reset_bram_l1: got en=%b rst=%b we=%h din=%h addr=%h expected en=0 rst=1 we=0 din=0 addr=0",
               bram_en_1, bram_rst_1, bram_we_1, bram_din_1, bram_addr_1);
    end
    n_cmp++;
    if ({bram_en_2, bram_rst_2, bram_we_2, bram_din_2} !== {1'b0, 1'b1, 4'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_bram_l2: got en=%b rst=%b we=%h din=%h expected en=0 rst=1 we=0 din=0",
               bram_en_2, bram_rst_2, bram_we_2, bram_din_2);
    end
    rstn = 1'b1;
    tick();
    n_cmp++;
    if ({bram_clk_1, bram_rst_1} !== {1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL bram_clk_rst_high: got clk=%b rst=%b expected clk=1 rst=0", bram_clk_1, bram_rst_1);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bram_clk_1 !== 1'b0) begin
      n_bad++;
      $display("FAIL bram_clk_low: got %b expected 0", bram_clk_1);
    end
    tick();
  endtask

  // 143 strobes hold WAIT, the 144th starts a packet; full packet checked
  task automatic test_packet();
    int t_s, t_v1, t_v2;
    logic [32:0] exp;
    write_ptr = 14'd0;
    enable    = 1'b1;
    tready    = 1'b1;
    tick();
    strobes(143);
    repeat (3) tick();
    n_cmp++;
    if ({state_1, state_2, tvalid_1, tvalid_2} !== {2'd1, 2'd1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL wait_143: got st1=%0d st2=%0d tv1=%b tv2=%b expected st=1 tv=0",
               state_1, state_2, tvalid_1, tvalid_2);
    end
    n_cmp++;
    if (occ_1 !== 15'd143) begin
      n_bad++;
      $display("FAIL occ_143: got %0d expected 143", occ_1);
    end
    strobes(1);
    t_s = -1; t_v1 = -1; t_v2 = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (t_s  < 0 && state_1 == 2'd2) t_s  = k;
      if (t_v1 < 0 && tvalid_1)        t_v1 = k;
      if (t_v2 < 0 && tvalid_2)        t_v2 = k;
    end
    tick();
    n_cmp++;
    if (t_s < 0 || t_v1 - t_s !== 2) begin
      n_bad++;
      $display("FAIL first_valid_l1: got %0d cycles expected 2", t_v1 - t_s);
    end
    n_cmp++;
    if (t_s < 0 || t_v2 - t_s !== 3) begin
      n_bad++;
      $display("FAIL first_valid_l2: got %0d cycles expected 3", t_v2 - t_s);
    end
    wait_words(PW, 400, 1'b0);
    n_cmp++;
    if (q1.size() !== PW || q2.size() !== PW) begin
      n_bad++;
      $display("FAIL pkt_len: got %0d/%0d expected %0d", q1.size(), q2.size(), PW);
    end
    for (int i = 0; i < PW && i < q1.size() && i < q2.size(); i++) begin
      exp = {(i == PW - 1) ? 1'b1 : 1'b0, word_of(14'(i))};
      n_cmp++;
      if (q1[i] !== exp || q2[i] !== exp) begin
        n_bad++;
        $display("FAIL pkt_word[%0d]: got %h/%h expected %h", i, q1[i], q2[i], exp);
      end
    end
    n_cmp++;
    if (stamp1.size() != PW || stamp1[PW-1] - stamp1[0] !== PW - 1) begin
      n_bad++;
      $display("FAIL sustained_rate: got span %0d expected %0d",
               (stamp1.size() == PW) ? stamp1[PW-1] - stamp1[0] : -1, PW - 1);
    end
    n_cmp++;
    if ({read_ptr_1, read_ptr_2, state_1, state_2, occ_1} !== {14'd144, 14'd144, 2'd1, 2'd1, 15'd0}) begin
      n_bad++;
      $display("FAIL pkt_end_status: got rp=%0d/%0d st=%0d/%0d occ=%0d expected rp=144 st=1 occ=0",
               read_ptr_1, read_ptr_2, state_1, state_2, occ_1);
    end
    clear_queues();
  endtask

  // Start near the top of the ring so the packet wraps 16383 -> 0
  task automatic test_wrap();
    logic [13:0] a;
    logic [32:0] exp;
    enable = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (state_1 !== 2'd0) begin
      n_bad++;
      $display("FAIL wait_to_idle: got %0d expected 0", state_1);
    end
    write_ptr = 14'd16380;
    enable    = 1'b1;
    tick();
    strobes(PW);
    wait_words(PW, 400, 1'b0);
    n_cmp++;
    if (q1.size() !== PW || q2.size() !== PW) begin
      n_bad++;
      $display("FAIL wrap_len: got %0d/%0d expected %0d", q1.size(), q2.size(), PW);
    end
    for (int i = 0; i < PW && i < q1.size() && i < q2.size(); i++) begin
      a   = 14'd16380 + 14'(i);
      exp = {(i == PW - 1) ? 1'b1 : 1'b0, word_of(a)};
      n_cmp++;
      if (q1[i] !== exp || q2[i] !== exp) begin
        n_bad++;
        $display("FAIL wrap_word[%0d]: got %h/%h expected %h", i, q1[i], q2[i], exp);
      end
    end
    n_cmp++;
    if (read_ptr_1 !== 14'd140 || read_ptr_2 !== 14'd140) begin
      n_bad++;
      $display("FAIL wrap_read_ptr: got %0d/%0d expected 140", read_ptr_1, read_ptr_2);
    end
    clear_queues();
  endtask

  // Two back-to-back packets under 30% tready after a fully stalled fill
  task automatic test_random_tready();
    logic [13:0] a;
    logic [32:0] exp;
    stall_err1 = 0;
    stall_err2 = 0;
    tready = 1'b0;
    strobes(2 * PW);
    wait_words(2 * PW, 4000, 1'b1);
    n_cmp++;
    if (q1.size() !== 2 * PW || q2.size() !== 2 * PW) begin
      n_bad++;
      $display("FAIL rnd_len: got %0d/%0d expected %0d", q1.size(), q2.size(), 2 * PW);
    end
    for (int i = 0; i < 2 * PW && i < q1.size() && i < q2.size(); i++) begin
      a   = 14'd140 + 14'(i);
      exp = {(i % PW == PW - 1) ? 1'b1 : 1'b0, word_of(a)};
      n_cmp++;
      if (q1[i] !== exp || q2[i] !== exp) begin
        n_bad++;
        $display("FAIL rnd_word[%0d]: got %h/%h expected %h", i, q1[i], q2[i], exp);
      end
    end
    n_cmp++;
    if (stall_err1 !== 0 || stall_err2 !== 0) begin
      n_bad++;
      $display("FAIL stall_stable: got %0d/%0d changes expected 0", stall_err1, stall_err2);
    end
    n_cmp++;
    if ({read_ptr_1, read_ptr_2, occ_1, occ_2} !== {14'd428, 14'd428, 15'd0, 15'd0}) begin
      n_bad++;
      $display("FAIL rnd_end_status: got rp=%0d/%0d occ=%0d/%0d expected rp=428 occ=0",
               read_ptr_1, read_ptr_2, occ_1, occ_2);
    end
    clear_queues();
  endtask

  task automatic test_overflow();
    enable = 1'b0;
    tready = 1'b0;
    repeat (2) tick();
    strobes(DEPTH);
    n_cmp++;
    if ({occ_1, ovf_1, ovf_cnt_1} !== {15'd16384, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL ovf_full: got occ=%0d ovf=%b cnt=%0d expected occ=16384 ovf=0 cnt=0", occ_1, ovf_1, ovf_cnt_1);
    end
    strobes(1);
    n_cmp++;
    if ({occ_1, ovf_1, ovf_cnt_1, ovf_2, ovf_cnt_2} !== {15'd16384, 1'b1, 16'd1, 1'b1, 16'd1}) begin
      n_bad++;
      $display("FAIL ovf_event: got occ=%0d ovf=%b/%b cnt=%0d/%0d expected occ=16384 ovf=1 cnt=1",
               occ_1, ovf_1, ovf_2, ovf_cnt_1, ovf_cnt_2);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++;
    if ({ovf_1, ovf_cnt_1, ovf_2, ovf_cnt_2} !== '0) begin
      n_bad++;
      $display("FAIL ovf_clear: got ovf=%b/%b cnt=%0d/%0d expected 0", ovf_1, ovf_2, ovf_cnt_1, ovf_cnt_2);
    end
    clear     = 1'b1;
    wr_strobe = 1'b1;
    tick();
    clear     = 1'b0;
    wr_strobe = 1'b0;
    n_cmp++;
    if ({ovf_1, ovf_cnt_1} !== '0) begin
      n_bad++;
      $display("FAIL ovf_clear_wins: got ovf=%b cnt=%0d expected 0", ovf_1, ovf_cnt_1);
    end
    strobes(2);
    n_cmp++;
    if ({ovf_1, ovf_cnt_1, occ_1} !== {1'b1, 16'd2, 15'd16384}) begin
      n_bad++;
      $display("FAIL ovf_count2: got ovf=%b cnt=%0d occ=%0d expected ovf=1 cnt=2 occ=16384", ovf_1, ovf_cnt_1, occ_1);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Enable dropped mid-packet: packet completes, passes through DRAIN to IDLE
  task automatic test_drain();
    bit seen1, seen2, done;
    int k;
    logic [32:0] exp;
    write_ptr = 14'd100;
    enable    = 1'b1;
    tready    = 1'b1;
    tick();
    strobes(PW);
    k = 0;
    while (q1.size() < 50 && k < 200) begin
      tick();
      k++;
    end
    enable = 1'b0;
    seen1 = 1'b0; seen2 = 1'b0; done = 1'b0; k = 0;
    while (!done && k < 400) begin
      if (state_1 == 2'd3) seen1 = 1'b1;
      if (state_2 == 2'd3) seen2 = 1'b1;
      done = (q1.size() >= PW) && (q2.size() >= PW) && (state_1 == 2'd0) && (state_2 == 2'd0);
      tick();
      k++;
    end
    repeat (4) tick();
    n_cmp++;
    if ({seen1, seen2, state_1, state_2} !== {1'b1, 1'b1, 2'd0, 2'd0}) begin
      n_bad++;
      $display("FAIL drain_seq: got drain_seen=%b/%b st=%0d/%0d expected drain_seen=1 st=0",
               seen1, seen2, state_1, state_2);
    end
    n_cmp++;
    if (q1.size() !== PW || q2.size() !== PW) begin
      n_bad++;
      $display("FAIL drain_len: got %0d/%0d expected %0d", q1.size(), q2.size(), PW);
    end
    for (int i = 0; i < PW && i < q1.size() && i < q2.size(); i++) begin
      exp = {(i == PW - 1) ? 1'b1 : 1'b0, word_of(14'd100 + 14'(i))};
      n_cmp++;
      if (q1[i] !== exp || q2[i] !== exp) begin
        n_bad++;
        $display("FAIL drain_word[%0d]: got %h/%h expected %h", i, q1[i], q2[i], exp);
      end
    end
    clear_queues();
  endtask

  // Reset mid-packet clears everything asynchronously; nothing follows it
  task automatic test_reset_mid_packet();
    int k;
    write_ptr = 14'd0;
    enable    = 1'b1;
    tready    = 1'b1;
    tick();
    strobes(PW);
    k = 0;
    while (q1.size() < 20 && k < 200) begin
      tick();
      k++;
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({tvalid_1, tvalid_2, tlast_1, tlast_2} !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_mid_axis: got tv=%b/%b tl=%b/%b expected 0", tvalid_1, tvalid_2, tlast_1, tlast_2);
    end
    n_cmp++;
    if ({state_1, read_ptr_1, occ_1, ovf_1, ovf_cnt_1, state_2, read_ptr_2, occ_2} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_status: got st=%0d rp=%0d occ=%0d ovf=%b cnt=%0d st2=%0d rp2=%0d occ2=%0d expected 0",
               state_1, read_ptr_1, occ_1, ovf_1, ovf_cnt_1, state_2, read_ptr_2, occ_2);
    end
    enable = 1'b0;
    repeat (2) tick();
    clear_queues();
    rstn = 1'b1;
    repeat (30) tick();
    n_cmp++;
    if (q1.size() !== 0 || q2.size() !== 0 || tvalid_1 !== 1'b0 || tvalid_2 !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_no_output: got words=%0d/%0d tv=%b/%b expected none",
               q1.size(), q2.size(), tvalid_1, tvalid_2);
    end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_wrap();
    test_random_tready();
    test_overflow();
    test_drain();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
